// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR filter.
//   state_e    : sequencer states (IDLE, MAC, OUT)
//   sat_t      : clamped value plus an overflow bit, returned by saturate()
//   acc_width  : accumulator width that cannot wrap for an n-tap dot product
//   saturate   : clamps a signed value into a signed field of the given width
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  typedef struct packed {
    logic signed [63:0] val;
    logic               ovf;
  } sat_t;

  // n products of two dw-bit signed values each fit in 2*dw bits, and
  // summing n of them needs clog2(n) extra bits of headroom.
  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic sat_t saturate(input logic signed [63:0] value, input int width);
    sat_t               r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi    = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (width - 1));
    r.val = value;
    r.ovf = 1'b0;
    if (value > hi) begin
      r.val = hi;
      r.ovf = 1'b1;
    end else if (value < lo) begin
      r.val = lo;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Single multiplier-accumulator shared by all taps.
//   clk, reset : clock and synchronous active-low reset
//   clear      : zero the accumulator (start of a new sample)
//   en         : add tap*coef into the accumulator this cycle
//   tap, coef  : signed operands for the current tap index
//   y_sat      : (acc + tap*coef) >>> SHIFT, clamped to DATA_WIDTH
//   ovf        : the clamp in y_sat is active
// y_sat looks at the sum including the current product, so the sequencer can
// capture the finished result on the same edge as the last accumulation.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4,
  parameter int SHIFT      = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] tap,
  input  logic signed [DATA_WIDTH-1:0] coef,
  output logic signed [DATA_WIDTH-1:0] y_sat,
  output logic                         ovf
);

  localparam int ACC_W  = acc_width(DATA_WIDTH, N);
  localparam int PROD_W = 2 * DATA_WIDTH;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  sat_t                     sat_r;

  always_comb begin
    prod    = PROD_W'(tap) * PROD_W'(coef);
    sum     = acc_q + ACC_W'(prod);
    shifted = sum >>> SHIFT;
    sat_r   = saturate(64'(shifted), DATA_WIDTH);
    acc_d   = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign y_sat = DATA_WIDTH'(sat_r.val);
  assign ovf   = sat_r.ovf;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed N-tap FIR controller around one multiplier-accumulator.
//   clk, reset             : clock, synchronous active-low reset
//   in_valid/in_ready/x_in : sample input handshake (accepted only in IDLE)
//   out_valid/out_ready    : result output handshake, y_out held until taken
//   y_out                  : signed saturated filter output
//   coef_we/addr/data      : coefficient RAM write port (honoured in IDLE)
//   coef_ready             : coefficient writes are honoured this cycle
//   flush                  : clear the delay line (in IDLE)
//   sat_flag               : sticky, some output was clamped
//   busy                   : sequencer not in IDLE
// Accepting a sample takes N MAC cycles, then the result waits in OUT until
// the consumer takes it.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SHIFT      = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] y_out,
  input  logic                         coef_we,
  input  logic [$clog2(N)-1:0]         coef_addr,
  input  logic signed [DATA_WIDTH-1:0] coef_data,
  output logic                         coef_ready,
  input  logic                         flush,
  output logic                         sat_flag,
  output logic                         busy
);

  localparam int AW = $clog2(N);

  state_e                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] tap_q  [N];
  logic signed [DATA_WIDTH-1:0] tap_d  [N];
  logic signed [DATA_WIDTH-1:0] coef_q [N];
  logic signed [DATA_WIDTH-1:0] coef_d [N];
  logic [AW-1:0]                idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0] y_q, y_d;
  logic                         sat_q, sat_d;
  logic [(1<<AW)-1:0]           addr_mask;
  logic                         mac_clear;
  logic                         mac_en;
  logic                         mac_ovf;
  logic signed [DATA_WIDTH-1:0] mac_y;

  assign in_ready   = (state_q == IDLE);
  assign coef_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == OUT);
  assign y_out      = y_q;
  assign sat_flag   = sat_q;

  // Addresses at or beyond N have no RAM entry; this mask drops such writes
  // when N is not a power of two.
  always_comb begin
    addr_mask = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      addr_mask[i] = (i < N);
    end
  end

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    coef_d    = coef_q;
    idx_d     = idx_q;
    y_d       = y_q;
    sat_d     = sat_q;
    mac_clear = 1'b0;
    mac_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (coef_we && addr_mask[coef_addr]) begin
          coef_d[coef_addr] = coef_data;
        end
        if (flush) begin
          for (int k = 0; k < N; k++) begin
            tap_d[k] = '0;
          end
        end
        // Shift on top of the (possibly flushed) line so flush+accept
        // leaves {x_in, 0, ..., 0}.
        if (in_valid) begin
          for (int k = N - 1; k > 0; k--) begin
            tap_d[k] = tap_d[k-1];
          end
          tap_d[0]  = x_in;
          mac_clear = 1'b1;
          idx_d     = '0;
          state_d   = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (idx_q == AW'(N - 1)) begin
          y_d     = mac_y;
          sat_d   = sat_q | mac_ovf;
          idx_d   = '0;
          state_d = OUT;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
      for (int k = 0; k < N; k++) begin
        tap_q[k]  <= '0;
        coef_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
      tap_q   <= tap_d;
      coef_q  <= coef_d;
    end
  end

  fir_mac_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .N         (N),
    .SHIFT     (SHIFT)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .clear(mac_clear),
    .en   (mac_en),
    .tap  (tap_q[idx_q]),
    .coef (coef_q[idx_q]),
    .y_sat(mac_y),
    .ovf  (mac_ovf)
  );

endmodule
